// File: rtl/uart_tx_if.sv
// uart_tx_if: byte push handshake into the UART transmitter FIFO.
interface uart_tx_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small transmit FIFO, LSB-first, registered TX.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after data bit 7).
module uart_tx #(
  parameter int BIT_RATE   = 9600,
  parameter int CLK_HZ     = 12_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus,
  output logic      tx_o,
  output logic      busy_o
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW:0]   count_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    head;
  logic          push, pop, nonempty, last;
  assign head     = mem_q[rptr_q];
  assign nonempty = count_q != '0;
  assign last     = cnt_q == LAST;
  assign bus.ready = rst_n && (count_q != FULL);
  assign push     = bus.valid && bus.ready;
  assign tx_o     = tx_q;
  assign busy_o   = (state_q != IDLE) || nonempty;
`ifdef UART_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else if (pop) par_q <= ^head;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (nonempty) begin
        pop     = 1'b1;
        state_d = START;
      end
      START: if (last) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (last) begin
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) state_d = STOP;
`endif
      STOP: if (last) begin
        pop     = nonempty;
        state_d = nonempty ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = head;
    // TX is registered, so it is driven from the state being entered
`ifdef UART_TX_PARITY_EN
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
           (state_d == PARITY) ? par_q : 1'b1;
`else
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= bus.data;
endmodule
